// File: rtl/mem_access_unit.sv
// Memory-stage data bus access unit: aligns stores, extends loads, and stalls
// the pipeline while an access is in flight on the data bus.
// Ports:
//   clk, rst                  - clock, synchronous active-high reset
//   M_mem_write, M_result_src - store / load request from the E/M register
//   M_type_control            - access size (00 word, 01 half, 10 byte, 11 word)
//   M_sign_ext_flag           - 1 sign-extends loads, 0 zero-extends
//   M_alu_result              - byte address
//   M_write_data              - right-aligned store data
//   mem_stall                 - freezes upstream pipeline registers while 1
//   M_read_data               - extended load result, valid when mem_stall=0
//   M_misaligned              - access fault flag
//   dbus_*                    - data bus request/response
//   stall_cnt                 - saturating count of stalled cycles
module mem_access_unit #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  M_mem_write,
    input  logic [1:0]            M_result_src,
    input  logic [1:0]            M_type_control,
    input  logic                  M_sign_ext_flag,
    input  logic [DATA_WIDTH-1:0] M_alu_result,
    input  logic [DATA_WIDTH-1:0] M_write_data,
    output logic                  mem_stall,
    output logic [DATA_WIDTH-1:0] M_read_data,
    output logic                  M_misaligned,
    output logic                  dbus_req,
    output logic                  dbus_we,
    output logic [DATA_WIDTH-1:0] dbus_addr,
    output logic [DATA_WIDTH-1:0] dbus_wdata,
    output logic [3:0]            dbus_be,
    input  logic [DATA_WIDTH-1:0] dbus_rdata,
    input  logic                  dbus_ack,
    output logic [15:0]           stall_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic                  access;
    logic                  is_half;
    logic                  is_byte;
    logic                  misaligned;
    logic                  capture;
    logic [3:0]            st_be;
    logic [DATA_WIDTH-1:0] st_wdata;

    logic [DATA_WIDTH-1:0] addr_q;
    logic                  we_q;
    logic [3:0]            be_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [1:0]            size_q;
    logic                  sign_q;
    logic [DATA_WIDTH-1:0] rdata_q;

    logic [7:0]            lane_b;
    logic [15:0]           lane_h;
    logic [DATA_WIDTH-1:0] load_ext;

    assign access  = M_mem_write | (M_result_src == 2'b01);
    assign is_half = (M_type_control == 2'b01);
    assign is_byte = (M_type_control == 2'b10);

    // Codes 00 and 11 are both word accesses.
    assign misaligned = access &
                        ((is_half & M_alu_result[0]) |
                         (~is_half & ~is_byte & (M_alu_result[1:0] != 2'b00)));

    assign M_misaligned = misaligned;

    // Store lane placement from the live request; captured on entry to BUSY.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = M_write_data;
        case (M_type_control)
            2'b10: begin
                st_be    = 4'b0001 << M_alu_result[1:0];
                st_wdata = {4{M_write_data[7:0]}};
            end
            2'b01: begin
                st_be    = M_alu_result[1] ? 4'b1100 : 4'b0011;
                st_wdata = {2{M_write_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = M_write_data;
            end
        endcase
    end

    // Load lane selection uses the captured address and size.
    always_comb begin
        lane_b   = 8'h00;
        lane_h   = addr_q[1] ? dbus_rdata[31:16] : dbus_rdata[15:0];
        load_ext = dbus_rdata;
        case (addr_q[1:0])
            2'd0:    lane_b = dbus_rdata[7:0];
            2'd1:    lane_b = dbus_rdata[15:8];
            2'd2:    lane_b = dbus_rdata[23:16];
            default: lane_b = dbus_rdata[31:24];
        endcase
        case (size_q)
            2'b10:   load_ext = {{24{sign_q & lane_b[7]}}, lane_b};
            2'b01:   load_ext = {{16{sign_q & lane_h[15]}}, lane_h};
            default: load_ext = dbus_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        mem_stall = 1'b0;
        dbus_req  = 1'b0;
        capture   = 1'b0;
        case (state_q)
            IDLE: begin
                if (access && !misaligned) begin
                    mem_stall = 1'b1;
                    capture   = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                mem_stall = 1'b1;
                dbus_req  = 1'b1;
                if (dbus_ack) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                // The pipeline advances at this edge, so never re-accept the
                // request still sitting in E/M.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign dbus_addr   = {addr_q[DATA_WIDTH-1:2], 2'b00};
    assign dbus_we     = we_q & (state_q == BUSY);
    assign dbus_be     = be_q;
    assign dbus_wdata  = wdata_q;
    assign M_read_data = (state_q == DONE) ? rdata_q : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            we_q      <= 1'b0;
            be_q      <= 4'b0000;
            wdata_q   <= '0;
            size_q    <= 2'b00;
            sign_q    <= 1'b0;
            rdata_q   <= '0;
            stall_cnt <= 16'h0000;
        end else begin
            state_q <= state_d;
            if (capture) begin
                addr_q  <= M_alu_result;
                we_q    <= M_mem_write;
                be_q    <= M_mem_write ? st_be : 4'b1111;
                wdata_q <= M_mem_write ? st_wdata : '0;
                size_q  <= M_type_control;
                sign_q  <= M_sign_ext_flag;
            end
            if (state_q == BUSY && dbus_ack) begin
                rdata_q <= we_q ? '0 : load_ext;
            end
            if (mem_stall && stall_cnt != 16'hFFFF) begin
                stall_cnt <= stall_cnt + 16'd1;
            end
        end
    end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter: DATA_WIDTH, default 32, data/address width; only 32 is supported.
REQ-002 clk  in  1  clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 M_mem_write  in  1  store request from the E/M register.
REQ-005 M_result_src  in  2  value 2'b01 marks a load.
REQ-006 M_type_control  in  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
REQ-007 M_sign_ext_flag  in  1  1 = sign-extend load, 0 = zero-extend.
REQ-008 M_alu_result  in  32  byte address.
REQ-009 M_write_data  in  32  store data, right-aligned.
REQ-010 mem_stall  out  1  freezes all upstream pipeline registers, including E/M enable, while 1.
REQ-011 M_read_data  out  32  extended load result, valid when mem_stall=0.
REQ-012 M_misaligned  out  1  access fault flag.
REQ-013 dbus_req, dbus_we  out  1 each  bus request and write strobe.
REQ-014 dbus_addr  out  32  word-aligned address, bits [1:0]=0.
REQ-015 dbus_wdata  out  32, dbus_be  out  4  lane-replicated store data and byte enables.
REQ-016 dbus_rdata  in  32, dbus_ack  in  1  read word and one-cycle completion pulse.
REQ-017 stall_cnt  out  16  saturating count of cycles with mem_stall=1.

Function
REQ-018 Access exists when M_mem_write=1 or M_result_src=01; both set = store.
REQ-019 Misaligned when half with addr[0]=1, or word with addr[1:0]!=0; then M_misaligned=1 combinationally, no bus request, mem_stall=0, M_read_data=0.
REQ-020 FSM states: IDLE, BUSY, DONE.
REQ-021 IDLE: aligned access -> mem_stall=1, capture address, we, be, wdata, size, sign flag into registers, go BUSY; no access -> stay IDLE, mem_stall=0.
REQ-022 BUSY: dbus_req=1, mem_stall=1; dbus_addr, dbus_we, dbus_be, dbus_wdata driven from captured registers, stable until ack.
REQ-023 BUSY with dbus_ack=1: register extended load data (0 for stores), go DONE; ack in the first BUSY cycle is legal.
REQ-024 DONE: mem_stall=0, M_read_data = registered value, dbus_req=0, unconditionally go IDLE next cycle.
REQ-025 Minimum access latency: 3 cycles (IDLE, BUSY, DONE), with pipeline advancing at the DONE edge.
REQ-026 dbus_ack outside BUSY is ignored.
REQ-027 Store be: byte = 1<<addr[1:0]; half = 0011 (addr[1]=0) or 1100; word = 1111.
REQ-028 Store wdata: byte = {4{wd[7:0]}}, half = {2{wd[15:0]}}, word = wd.
REQ-029 Load: select byte lane addr[1:0] or half lane addr[1], extend to 32 bits per sign flag; word unchanged.
REQ-030 dbus_we=0 and dbus_be=1111 for all loads.
REQ-031 stall_cnt increments each cycle mem_stall=1, saturates at 16'hFFFF.

Reset
REQ-032 rst=1 at edge: state IDLE, captured registers 0, M_read_data register 0, stall_cnt 0.
REQ-033 While in IDLE after reset, dbus_req=0, mem_stall follows REQ-021 combinationally.
REQ-034 rst during BUSY abandons the transaction: dbus_req=0 the next cycle, a later ack is ignored.

Verification
REQ-035 Load byte addr 0x103, signed, rdata 0x80FF_FF12 -> BUSY with addr 0x100, be 1111; DONE M_read_data 0xFFFF_FF80.
REQ-036 Store half addr 0x202, wd 0x0000_BEEF, ack after 4 BUSY cycles -> be 1100, wdata 0xBEEF_BEEF, mem_stall high 5 cycles, stall_cnt=5.
REQ-037 Load word addr 0x101 -> M_misaligned=1, dbus_req never 1, mem_stall=0.
REQ-038 Load half addr 0x002 unsigned, rdata 0xABCD_1234, ack in first BUSY cycle -> M_read_data 0x0000_ABCD at cycle 3.
REQ-039 rst asserted in BUSY, ack next cycle -> state IDLE, dbus_req=0, ack ignored, M_read_data 0.
REQ-040 Stall held 70000 cycles -> stall_cnt = 0xFFFF, no wrap.
